// File: rtl/alu_control_seq.sv
// ALU control decoder with a multi-cycle multiply/divide sequencer.
// Optional macro ALU_SHIFT_OPS_EN adds SLL/SRL decode and the shamt_sel_o port.
module alu_control_seq #(
    parameter int OPER_W      = 4,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [2:0]        alu_op_i,
    input  logic [5:0]        alu_function_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic [OPER_W-1:0] alu_operation_o,
    output logic              op_valid_o,
    output logic              illegal_o,
    output logic              md_start_o,
    output logic              md_busy_o,
`ifdef ALU_SHIFT_OPS_EN
    output logic              md_done_o,
    output logic              shamt_sel_o
`else
    output logic              md_done_o
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } state_t;

    // Decode result packed as {illegal, is_mult, is_div, code[3:0]}
    function automatic logic [6:0] decode(input logic [2:0] op, input logic [5:0] funct);
        logic [6:0] r;
        r = {1'b1, 1'b0, 1'b0, 4'b1001};
        case (op)
            3'b111: begin
                case (funct)
                    6'b100000: r = {1'b0, 1'b0, 1'b0, 4'b0011};
                    6'b100010: r = {1'b0, 1'b0, 1'b0, 4'b0100};
                    6'b100101: r = {1'b0, 1'b0, 1'b0, 4'b0010};
                    6'b100100: r = {1'b0, 1'b0, 1'b0, 4'b0110};
                    6'b100111: r = {1'b0, 1'b0, 1'b0, 4'b0111};
                    6'b101010: r = {1'b0, 1'b0, 1'b0, 4'b1000};
                    6'b011000: r = {1'b0, 1'b1, 1'b0, 4'b1100};
                    6'b011001: r = {1'b0, 1'b1, 1'b0, 4'b1100};
                    6'b011010: r = {1'b0, 1'b0, 1'b1, 4'b1101};
                    6'b011011: r = {1'b0, 1'b0, 1'b1, 4'b1101};
`ifdef ALU_SHIFT_OPS_EN
                    6'b000000: r = {1'b0, 1'b0, 1'b0, 4'b1010};
                    6'b000010: r = {1'b0, 1'b0, 1'b0, 4'b1011};
`endif
                    default:   r = {1'b1, 1'b0, 1'b0, 4'b1001};
                endcase
            end
            3'b100:  r = {1'b0, 1'b0, 1'b0, 4'b0011};
            3'b101:  r = {1'b0, 1'b0, 1'b0, 4'b0010};
            3'b001:  r = {1'b0, 1'b0, 1'b0, 4'b0110};
            3'b110:  r = {1'b0, 1'b0, 1'b0, 4'b0101};
            3'b010:  r = {1'b0, 1'b0, 1'b0, 4'b1000};
            default: r = {1'b1, 1'b0, 1'b0, 4'b1001};
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [OPER_W-1:0] oper_q, oper_d;
    logic              op_valid_q, op_valid_d;
    logic              illegal_q, illegal_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [6:0]        dec_s;
`ifdef ALU_SHIFT_OPS_EN
    logic              shamt_q, shamt_d;
    logic              is_shift_s;
`endif

    assign dec_s = decode(alu_op_i, alu_function_i);
`ifdef ALU_SHIFT_OPS_EN
    assign is_shift_s = (alu_op_i == 3'b111) &&
                        ((alu_function_i == 6'b000000) || (alu_function_i == 6'b000010));
`endif

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        oper_d     = oper_q;
        op_valid_d = 1'b0;
        illegal_d  = 1'b0;
        start_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
`ifdef ALU_SHIFT_OPS_EN
        shamt_d    = shamt_q;
`endif
        if (flush_i) begin
            // Abort wins over everything, including a same-cycle request
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        oper_d = OPER_W'(dec_s[3:0]);
`ifdef ALU_SHIFT_OPS_EN
                        shamt_d = is_shift_s;
`endif
                        if (dec_s[5]) begin
                            state_d = MD_BUSY;
                            cnt_d   = 8'(MULT_CYCLES - 1);
                            start_d = 1'b1;
                            busy_d  = 1'b1;
                        end else if (dec_s[4]) begin
                            state_d = MD_BUSY;
                            cnt_d   = 8'(DIV_CYCLES - 1);
                            start_d = 1'b1;
                            busy_d  = 1'b1;
                        end else begin
                            op_valid_d = 1'b1;
                            illegal_d  = dec_s[6];
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                MD_BUSY: begin
                    if (cnt_q == 8'd0) begin
                        state_d    = MD_DONE;
                        done_d     = 1'b1;
                        op_valid_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q - 8'd1;
                        busy_d = 1'b1;
                    end
                end
                MD_DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            oper_q     <= '0;
            op_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef ALU_SHIFT_OPS_EN
            shamt_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            oper_q     <= oper_d;
            op_valid_q <= op_valid_d;
            illegal_q  <= illegal_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef ALU_SHIFT_OPS_EN
            shamt_q    <= shamt_d;
`endif
        end
    end

    assign ready_o         = (state_q == IDLE);
    assign alu_operation_o = oper_q;
    assign op_valid_o      = op_valid_q;
    assign illegal_o       = illegal_q;
    assign md_start_o      = start_q;
    assign md_busy_o       = busy_q;
    assign md_done_o       = done_q;
`ifdef ALU_SHIFT_OPS_EN
    assign shamt_sel_o     = shamt_q;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed, table-driven bench for alu_control_seq (default parameters).
module tb_alu_control_seq;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_i;
    logic [2:0] alu_op_i;
    logic [5:0] alu_function_i;
    logic       flush_i;
    logic       ready_o;
    logic [3:0] alu_operation_o;
    logic       op_valid_o, illegal_o, md_start_o, md_busy_o, md_done_o;
`ifdef ALU_SHIFT_OPS_EN
    logic       shamt_sel_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] op;
        logic [5:0] funct;
        logic [3:0] code;
        logic       ill;
        logic       sh;
    } vec_t;

    vec_t vecs[16];

    alu_control_seq dut (
        .clk             (clk),
        .reset           (reset),
        .valid_i         (valid_i),
        .alu_op_i        (alu_op_i),
        .alu_function_i  (alu_function_i),
        .flush_i         (flush_i),
        .ready_o         (ready_o),
        .alu_operation_o (alu_operation_o),
        .op_valid_o      (op_valid_o),
        .illegal_o       (illegal_o),
        .md_start_o      (md_start_o),
        .md_busy_o       (md_busy_o),
`ifdef ALU_SHIFT_OPS_EN
        .md_done_o       (md_done_o),
        .shamt_sel_o     (shamt_sel_o)
`else
        .md_done_o       (md_done_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " code"}, 32'(alu_operation_o), 32'd0);
        chk({name, " pulses"}, {27'd0, op_valid_o, illegal_o, md_start_o, md_busy_o, md_done_o}, 32'd0);
        chk({name, " ready"}, 32'(ready_o), 32'd1);
`ifdef ALU_SHIFT_OPS_EN
        chk({name, " shamt"}, 32'(shamt_sel_o), 32'd0);
`endif
    endtask

    initial begin
        logic saw_done;

        vecs[0]  = '{3'b111, 6'b100010, 4'b0100, 1'b0, 1'b0};
        vecs[1]  = '{3'b110, 6'b000000, 4'b0101, 1'b0, 1'b0};
        vecs[2]  = '{3'b111, 6'b100000, 4'b0011, 1'b0, 1'b0};
        vecs[3]  = '{3'b111, 6'b100101, 4'b0010, 1'b0, 1'b0};
        vecs[4]  = '{3'b111, 6'b100100, 4'b0110, 1'b0, 1'b0};
        vecs[5]  = '{3'b111, 6'b100111, 4'b0111, 1'b0, 1'b0};
        vecs[6]  = '{3'b111, 6'b101010, 4'b1000, 1'b0, 1'b0};
        vecs[7]  = '{3'b100, 6'b101010, 4'b0011, 1'b0, 1'b0};
        vecs[8]  = '{3'b101, 6'b000000, 4'b0010, 1'b0, 1'b0};
        vecs[9]  = '{3'b001, 6'b100000, 4'b0110, 1'b0, 1'b0};
        vecs[10] = '{3'b010, 6'b011010, 4'b1000, 1'b0, 1'b0};
        vecs[11] = '{3'b011, 6'b100000, 4'b1001, 1'b1, 1'b0};
        vecs[12] = '{3'b000, 6'b100000, 4'b1001, 1'b1, 1'b0};
        vecs[13] = '{3'b111, 6'b111111, 4'b1001, 1'b1, 1'b0};
`ifdef ALU_SHIFT_OPS_EN
        vecs[14] = '{3'b111, 6'b000010, 4'b1011, 1'b0, 1'b1};
        vecs[15] = '{3'b111, 6'b000000, 4'b1010, 1'b0, 1'b1};
`else
        vecs[14] = '{3'b111, 6'b000010, 4'b1001, 1'b1, 1'b0};
        vecs[15] = '{3'b111, 6'b000000, 4'b1001, 1'b1, 1'b0};
`endif

        reset = 1'b1; valid_i = 1'b0; alu_op_i = 3'b000; alu_function_i = 6'b000000; flush_i = 1'b0;
        #2;
        chk_all_zero("reset");
        step();
        step();
        reset = 1'b0;
        step();

        // Back-to-back single-cycle decodes
        for (int i = 0; i < 16; i++) begin
            valid_i = 1'b1; alu_op_i = vecs[i].op; alu_function_i = vecs[i].funct;
            step();
            chk($sformatf("vec%0d code", i), 32'(alu_operation_o), 32'(vecs[i].code));
            chk($sformatf("vec%0d op_valid", i), 32'(op_valid_o), 32'd1);
            chk($sformatf("vec%0d illegal", i), 32'(illegal_o), 32'(vecs[i].ill));
            chk($sformatf("vec%0d ready", i), 32'(ready_o), 32'd1);
`ifdef ALU_SHIFT_OPS_EN
            chk($sformatf("vec%0d shamt", i), 32'(shamt_sel_o), 32'(vecs[i].sh));
`endif
        end
        valid_i = 1'b0;
        step();
        chk("hold op_valid", 32'(op_valid_o), 32'd0);
        chk("hold illegal", 32'(illegal_o), 32'd0);
        chk("hold code", 32'(alu_operation_o), 32'(vecs[15].code));

        // DIV: start pulse, N busy cycles, done; requests during busy ignored
        valid_i = 1'b1; alu_op_i = 3'b111; alu_function_i = 6'b011010;
        step();
        alu_function_i = 6'b100000;
        chk("div code", 32'(alu_operation_o), 32'hD);
        chk("div start", 32'(md_start_o), 32'd1);
        chk("div busy1", 32'(md_busy_o), 32'd1);
        chk("div ready1", 32'(ready_o), 32'd0);
        chk("div op_valid1", 32'(op_valid_o), 32'd0);
        for (int k = 2; k <= DIV_N; k++) begin
            step();
            chk($sformatf("div busy%0d", k), {29'd0, md_start_o, md_busy_o, ready_o}, 32'b010);
            chk($sformatf("div code%0d", k), 32'(alu_operation_o), 32'hD);
            chk($sformatf("div pulse%0d", k), {30'd0, op_valid_o, md_done_o}, 32'd0);
        end
        step();
        valid_i = 1'b0;
        chk("div done", {28'd0, md_done_o, op_valid_o, md_busy_o, ready_o}, 32'b1100);
        chk("div done illegal", 32'(illegal_o), 32'd0);
        chk("div done code", 32'(alu_operation_o), 32'hD);
        step();
        chk("div idle", {29'd0, md_done_o, op_valid_o, ready_o}, 32'b001);
        chk("div held code", 32'(alu_operation_o), 32'hD);

        // MULT flushed on its second busy cycle
        valid_i = 1'b1; alu_op_i = 3'b111; alu_function_i = 6'b011000;
        step();
        valid_i = 1'b0;
        chk("mult code", 32'(alu_operation_o), 32'hC);
        chk("mult start", 32'(md_start_o), 32'd1);
        step();
        chk("mult busy2", {30'd0, md_busy_o, md_start_o}, 32'b10);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush state", {28'd0, ready_o, md_busy_o, md_done_o, op_valid_o}, 32'b1000);
        saw_done = 1'b0;
        for (int k = 0; k < MULT_N + 2; k++) begin
            step();
            if (md_done_o || op_valid_o) saw_done = 1'b1;
        end
        chk("flush no done", 32'(saw_done), 32'd0);

        // Flush beats a same-cycle request
        valid_i = 1'b1; alu_op_i = 3'b111; alu_function_i = 6'b100000; flush_i = 1'b1;
        step();
        valid_i = 1'b0; flush_i = 1'b0;
        chk("flush+valid op_valid", 32'(op_valid_o), 32'd0);
        chk("flush+valid code", 32'(alu_operation_o), 32'hC);

        // Async reset in the middle of a MULTU
        valid_i = 1'b1; alu_op_i = 3'b111; alu_function_i = 6'b011001;
        step();
        valid_i = 1'b0;
        step();
        chk("pre-reset busy", 32'(md_busy_o), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("mid reset");
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < MULT_N + 2; k++) begin
            step();
            if (md_done_o || op_valid_o || md_busy_o) saw_done = 1'b1;
        end
        chk("reset no done", 32'(saw_done), 32'd0);
        chk("reset ready", 32'(ready_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

Interface
- REQ-001 Parameter OPER_W, default 4: width of alu_operation_o; legal values >=4; upper bits zero-extended.
- REQ-002 Parameter MULT_CYCLES, default 4: busy cycles for MULT/MULTU; legal range 2..255.
- REQ-003 Parameter DIV_CYCLES, default 8: busy cycles for DIV/DIVU; legal range 2..255.
- REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
- REQ-005 reset  input  1  asynchronous, active-high reset.
- REQ-006 valid_i  input  1  a decode request is present.
- REQ-007 alu_op_i  input  3  ALUOp from the main control unit.
- REQ-008 alu_function_i  input  6  instruction funct field.
- REQ-009 flush_i  input  1  synchronous abort of any in-flight operation.
- REQ-010 ready_o  output  1  block can accept a request this cycle.
- REQ-011 alu_operation_o  output  OPER_W  registered ALU operation code.
- REQ-012 op_valid_o  output  1  one-cycle pulse: alu_operation_o is final.
- REQ-013 illegal_o  output  1  one-cycle pulse, coincident with op_valid_o, for an undecodable request.
- REQ-014 md_start_o / md_busy_o / md_done_o  output  1 each  multiply/divide start pulse, busy level, done pulse.
- REQ-015 shamt_sel_o  output  1  shift-amount operand select (present only with ALU_SHIFT_OPS_EN).

Function
- REQ-016 Decode SHALL map: R-type (op 111) funct 100000 ADD->0011, 100010 SUB->0100, 100101 OR->0010, 100100 AND->0110, 100111 NOR->0111, 101010 SLT->1000, 011000/011001 MULT(U)->1100, 011010/011011 DIV(U)->1101; op 100 ADDI->0011, 101 ORI->0010, 001 ANDI->0110, 110 LUI->0101; op 010 SLTI->1000; anything else->1001 with illegal_o.
- REQ-017 A request SHALL be accepted on a rising edge where valid_i=1, ready_o=1 and flush_i=0.
- REQ-018 FSM states: IDLE, MD_BUSY, MD_DONE; ready_o=1 only in IDLE.
- REQ-019 Single-cycle op accepted at edge T: alu_operation_o and op_valid_o=1 (illegal_o if applicable) in cycle T+1; state stays IDLE, so back-to-back accepts yield one op_valid_o per cycle.
- REQ-020 MULT/DIV accepted at edge T: enter MD_BUSY; cycle T+1 shows code, md_start_o=1; counter loaded with N-1 (N = MULT_CYCLES or DIV_CYCLES).
- REQ-021 In MD_BUSY, md_busy_o=1, counter decrements each cycle; at counter==0 next state MD_DONE; md_busy_o high exactly N cycles.
- REQ-022 MD_DONE lasts one cycle with md_done_o=1, op_valid_o=1, md_busy_o=0; then IDLE.
- REQ-023 alu_operation_o SHALL hold its last value until the next accept.
- REQ-024 flush_i=1 in any state SHALL force IDLE at the next edge, clear counter, suppress op_valid_o/md_done_o/illegal_o that cycle; flush overrides simultaneous valid_i.
- REQ-025 valid_i while ready_o=0 SHALL be ignored without side effects.

Reset
- REQ-026 reset=1 SHALL immediately force IDLE, counter=0, alu_operation_o=0, op_valid_o=illegal_o=md_start_o=md_busy_o=md_done_o=0, shamt_sel_o=0, ready_o=1 while deasserted.
- REQ-027 Reset mid-MD_BUSY SHALL abort the operation with no md_done_o pulse afterwards.

Configuration
- REQ-028 Macro ALU_SHIFT_OPS_EN defined: R-type funct 000000 SLL->1010, 000010 SRL->1011, single-cycle, shamt_sel_o=1 registered alongside them (0 for all other ops).
- REQ-029 Macro undefined: shamt_sel_o port absent; funct 000000/000010 decode to 1001 with illegal_o.

Verification
- REQ-030 reset pulse mid-stream -> all outputs 0, ready_o=1 within same cycle.
- REQ-031 op 111 funct 100010 at T -> T+1 alu_operation_o=0100, op_valid_o=1; then op 110 at T+1 -> T+2 0101, op_valid_o=1.
- REQ-032 op 111 funct 011010, DIV_CYCLES=8 -> md_start_o 1 cycle, md_busy_o 8 cycles, md_done_o+op_valid_o next cycle, ready_o low 9 cycles; valid_i during busy ignored.
- REQ-033 MULT accepted, flush_i at busy cycle 2 -> IDLE next edge, no md_done_o, ready_o=1.
- REQ-034 op 011 -> alu_operation_o=1001, illegal_o=1, op_valid_o=1 one cycle.
- REQ-035 funct 000010 with/without ALU_SHIFT_OPS_EN -> 1011 and shamt_sel_o=1 / 1001 and illegal_o=1.
